// File: rtl/nv_nvdla_sdp_rdma_gather_if.sv
// Beat-in / word-out handshake bundle for the SDP RDMA gatherer.
// master drives beats and consumes words; slave is the gatherer itself.
interface nv_nvdla_sdp_rdma_gather_if #(
   parameter int unsigned IW = 256,
   parameter int unsigned OW = 512,
   parameter int unsigned CW = 1
);
   logic              inp_pvld;
   logic              inp_prdy;
   logic [IW+CW-1:0]  inp_data;
   logic              out_pvld;
   logic              out_prdy;
   logic [OW+CW-1:0]  out_data;

   modport master (
      output inp_pvld, inp_data, out_prdy,
      input  inp_prdy, out_pvld, out_data
   );

   modport slave (
      input  inp_pvld, inp_data, out_prdy,
      output inp_prdy, out_pvld, out_data
   );
endinterface

// File: rtl/nv_nvdla_sdp_rdma_gather.sv
// Narrow-to-wide beat gatherer: packs RATIO (or RATIO/2) tagged IW-bit beats
// into one OW-bit word; a non-zero tag closes the group early.
module nv_nvdla_sdp_rdma_gather #(
   parameter int unsigned IW = 256,
   parameter int unsigned OW = 512,
   parameter int unsigned CW = 1
) (
   input  logic                              nvdla_core_clk,
   input  logic                              nvdla_core_rstn,
   input  logic                              cfg_dp_8,
   nv_nvdla_sdp_rdma_gather_if.slave         ifc
);
   localparam int unsigned RATIO = OW / IW;
   localparam int unsigned HALF  = (RATIO > 1) ? RATIO / 2 : 1;
   localparam int unsigned CNTW  = 4;

   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] lim_c;
   logic [OW-1:0]   acc;
   logic [OW-1:0]   merged_c;
   logic [OW-1:0]   out_word;
   logic [CW-1:0]   out_tag;
   logic [CW-1:0]   in_tag_c;
   logic [IW-1:0]   in_dat_c;
   logic            out_pvld;
   logic            inp_prdy_c;
   logic            inp_acc_c;
   logic            out_acc_c;
   logic            last_c;

   assign in_tag_c   = ifc.inp_data[IW+CW-1:IW];
   assign in_dat_c   = ifc.inp_data[IW-1:0];
   // Ready depends only on the output side so no combinational loop through inp_pvld.
   assign inp_prdy_c = !out_pvld | ifc.out_prdy;
   assign inp_acc_c  = ifc.inp_pvld & inp_prdy_c;
   assign out_acc_c  = out_pvld & ifc.out_prdy;
   assign lim_c      = cfg_dp_8 ? CNTW'(RATIO - 1) : CNTW'(HALF - 1);
   assign last_c     = inp_acc_c & ((cnt == lim_c) | (in_tag_c != '0));

   assign ifc.inp_prdy = inp_prdy_c;
   assign ifc.out_pvld = out_pvld;
   assign ifc.out_data = {out_tag, out_word};

   // Accumulator with the current beat dropped into segment cnt; upper segments zeroed.
   always_comb begin
      merged_c = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (CNTW'(i) == cnt) begin
            merged_c[i*IW +: IW] = in_dat_c;
         end else if (CNTW'(i) < cnt) begin
            merged_c[i*IW +: IW] = acc[i*IW +: IW];
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cnt      <= '0;
         acc      <= '0;
         out_word <= '0;
         out_tag  <= '0;
         out_pvld <= 1'b0;
      end else if (last_c) begin
         out_word <= merged_c;
         out_tag  <= in_tag_c;
         out_pvld <= 1'b1;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         if (inp_acc_c) begin
            acc <= merged_c;
            cnt <= cnt + CNTW'(1);
         end
         if (out_acc_c) begin
            out_pvld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_gather.sv
// Directed bench for the SDP RDMA gatherer: RATIO=2 (IW=256) and RATIO=4 (IW=128) instances.
module tb_nv_nvdla_sdp_rdma_gather;
   logic clk;
   logic rstn;
   logic cfg2;
   logic cfg4;
   int   checks;
   int   failures;

   nv_nvdla_sdp_rdma_gather_if #(.IW(256), .OW(512), .CW(1)) i2 ();
   nv_nvdla_sdp_rdma_gather_if #(.IW(128), .OW(512), .CW(1)) i4 ();

   nv_nvdla_sdp_rdma_gather #(.IW(256), .OW(512), .CW(1)) u_d2 (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .cfg_dp_8        (cfg2),
      .ifc             (i2)
   );

   nv_nvdla_sdp_rdma_gather #(.IW(128), .OW(512), .CW(1)) u_d4 (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .cfg_dp_8        (cfg4),
      .ifc             (i4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] p2(input logic [31:0] s);
      return {8{s}};
   endfunction

   function automatic logic [127:0] p4(input logic [31:0] s);
      return {4{s}};
   endfunction

   task automatic chk1(input string nm, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", nm, obs, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [512:0] obs, input logic [512:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rstn        = 1'b0;
      cfg2        = 1'b1;
      cfg4        = 1'b1;
      i2.inp_pvld = 1'b0;
      i2.inp_data = '0;
      i2.out_prdy = 1'b1;
      i4.inp_pvld = 1'b0;
      i4.inp_data = '0;
      i4.out_prdy = 1'b1;

      // Reset state
      tick();
      tick();
      chk1("rst_pvld2", i2.out_pvld, 1'b0);
      chk1("rst_prdy2", i2.inp_prdy, 1'b1);
      chkw("rst_data2", i2.out_data, '0);
      chk1("rst_pvld4", i4.out_pvld, 1'b0);
      chk1("rst_prdy4", i4.inp_prdy, 1'b1);
      chkw("rst_data4", i4.out_data, '0);
      rstn = 1'b1;
      tick();

      // Basic full group, RATIO=2
      i2.inp_pvld = 1'b1;
      i2.inp_data = {1'b0, p2(32'hAAAA_0001)};
      tick();
      chk1("basic_mid_pvld", i2.out_pvld, 1'b0);
      i2.inp_data = {1'b0, p2(32'hBBBB_0002)};
      tick();
      chk1("basic_pvld", i2.out_pvld, 1'b1);
      chkw("basic_word", i2.out_data, {1'b0, p2(32'hBBBB_0002), p2(32'hAAAA_0001)});
      i2.inp_pvld = 1'b0;
      tick();
      chk1("basic_pvld_drop", i2.out_pvld, 1'b0);

      // Half mode: every beat is its own word
      cfg2 = 1'b0;
      i2.inp_pvld = 1'b1;
      i2.inp_data = {1'b0, p2(32'hAAAA_0011)};
      tick();
      chkw("half_a", i2.out_data, {1'b0, 256'h0, p2(32'hAAAA_0011)});
      i2.inp_data = {1'b0, p2(32'hBBBB_0012)};
      tick();
      chk1("half_b_pvld", i2.out_pvld, 1'b1);
      chkw("half_b", i2.out_data, {1'b0, 256'h0, p2(32'hBBBB_0012)});
      i2.inp_data = {1'b0, p2(32'hCCCC_0013)};
      tick();
      chkw("half_c", i2.out_data, {1'b0, 256'h0, p2(32'hCCCC_0013)});
      i2.inp_pvld = 1'b0;
      tick();
      chk1("half_idle", i2.out_pvld, 1'b0);
      cfg2 = 1'b1;

      // Tag on the limit beat: one word carrying the tag
      i2.inp_pvld = 1'b1;
      i2.inp_data = {1'b0, p2(32'hAAAA_0021)};
      tick();
      i2.inp_data = {1'b1, p2(32'hBBBB_0022)};
      tick();
      chkw("tag_lim", i2.out_data, {1'b1, p2(32'hBBBB_0022), p2(32'hAAAA_0021)});
      i2.inp_pvld = 1'b0;
      tick();
      chk1("tag_lim_once", i2.out_pvld, 1'b0);

      // Backpressure holds the word and stalls the input
      i2.inp_pvld = 1'b1;
      i2.inp_data = {1'b0, p2(32'hAAAA_0031)};
      tick();
      i2.inp_data = {1'b0, p2(32'hBBBB_0032)};
      tick();
      i2.out_prdy = 1'b0;
      i2.inp_data = {1'b0, p2(32'hCCCC_0033)};
      for (int c = 0; c < 5; c++) begin
         #1;
         chk1("bp_prdy", i2.inp_prdy, 1'b0);
         chkw("bp_hold", i2.out_data, {1'b0, p2(32'hBBBB_0032), p2(32'hAAAA_0031)});
         tick();
      end
      i2.out_prdy = 1'b1;
      #1;
      chk1("bp_release_prdy", i2.inp_prdy, 1'b1);
      tick();
      chk1("bp_drain", i2.out_pvld, 1'b0);
      i2.inp_data = {1'b0, p2(32'hDDDD_0034)};
      tick();
      chk1("bp_resume_pvld", i2.out_pvld, 1'b1);
      chkw("bp_resume", i2.out_data, {1'b0, p2(32'hDDDD_0034), p2(32'hCCCC_0033)});
      i2.inp_pvld = 1'b0;
      tick();

      // Back-to-back streaming, 8 beats -> 4 words
      i2.inp_pvld = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i2.inp_data = {1'b0, p2(32'hB0B0_0000 + 32'(k))};
         #1;
         chk1("b2b_prdy", i2.inp_prdy, 1'b1);
         tick();
         if ((k % 2) == 1) begin
            chk1("b2b_pvld", i2.out_pvld, 1'b1);
            chkw("b2b_word", i2.out_data,
                 {1'b0, p2(32'hB0B0_0000 + 32'(k)), p2(32'hB0B0_0000 + 32'(k - 1))});
         end else begin
            chk1("b2b_gap", i2.out_pvld, 1'b0);
         end
      end
      i2.inp_pvld = 1'b0;
      tick();

      // Early flush on RATIO=4, then a full group
      i4.inp_pvld = 1'b1;
      i4.inp_data = {1'b0, p4(32'hAAAA_0041)};
      tick();
      i4.inp_data = {1'b1, p4(32'hBBBB_0042)};
      tick();
      chk1("flush_pvld", i4.out_pvld, 1'b1);
      chkw("flush_word", i4.out_data,
           {1'b1, 128'h0, 128'h0, p4(32'hBBBB_0042), p4(32'hAAAA_0041)});
      i4.inp_data = {1'b0, p4(32'hCCCC_0043)};
      tick();
      chk1("flush_next_gap", i4.out_pvld, 1'b0);
      i4.inp_data = {1'b0, p4(32'hDDDD_0044)};
      tick();
      i4.inp_data = {1'b0, p4(32'hEEEE_0045)};
      tick();
      chk1("full4_mid", i4.out_pvld, 1'b0);
      i4.inp_data = {1'b0, p4(32'hFFFF_0046)};
      tick();
      chkw("full4_word", i4.out_data,
           {1'b0, p4(32'hFFFF_0046), p4(32'hEEEE_0045), p4(32'hDDDD_0044), p4(32'hCCCC_0043)});

      // Half mode on RATIO=4: two beats, upper half zero
      i4.inp_pvld = 1'b0;
      tick();
      cfg4 = 1'b0;
      i4.inp_pvld = 1'b1;
      i4.inp_data = {1'b0, p4(32'h1234_0051)};
      tick();
      i4.inp_data = {1'b0, p4(32'h1234_0052)};
      tick();
      chkw("half4_word", i4.out_data,
           {1'b0, 128'h0, 128'h0, p4(32'h1234_0052), p4(32'h1234_0051)});
      i4.inp_pvld = 1'b0;
      tick();

      // Reset mid-group discards the partial beat
      i2.inp_pvld = 1'b1;
      i2.inp_data = {1'b0, p2(32'hAAAA_0061)};
      tick();
      i2.inp_pvld = 1'b0;
      rstn = 1'b0;
      #1;
      chk1("midrst_pvld", i2.out_pvld, 1'b0);
      chkw("midrst_data", i2.out_data, '0);
      tick();
      tick();
      chk1("midrst_hold", i2.out_pvld, 1'b0);
      rstn = 1'b1;
      tick();
      i2.inp_pvld = 1'b1;
      i2.inp_data = {1'b0, p2(32'hBBBB_0062)};
      tick();
      chk1("midrst_b_only", i2.out_pvld, 1'b0);
      i2.inp_data = {1'b0, p2(32'hCCCC_0063)};
      tick();
      chkw("midrst_word", i2.out_data, {1'b0, p2(32'hCCCC_0063), p2(32'hBBBB_0062)});
      i2.inp_pvld = 1'b0;
      tick();
      chk1("midrst_single", i2.out_pvld, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
